// File: rtl/inbox_tx_sequencer_pkg.sv
// Shared types and constants for the INBOX -> UART TX sequencer.
// Holds the sequencer state encoding and the box FIFO geometry.
package inbox_tx_sequencer_pkg;

    localparam int BOX_DW     = 8;
    localparam int BOX_LGFLEN = 5;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_POP  = 3'd1,
        SEQ_SEND = 3'd2,
        SEQ_ACK  = 3'd3,
        SEQ_WAIT = 3'd4,
        SEQ_GAP  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/inbox_tx_sequencer.sv
// Pops INBOX bytes on request and hands each to txuartlite, one per frame.
// Optional OUTBOX copy when OUTBOX_COPY_EN is defined.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_step, i_run       single-byte request pulse / continuous drain level
//   i_inbox_empty_n     INBOX has data; i_inbox_data is its head
//   o_inbox_rd          INBOX pop strobe
//   i_tx_busy           txuartlite busy
//   o_tx_wr, o_tx_data  txuartlite write strobe and byte
//   i_outbox_full       OUTBOX full (only used with OUTBOX_COPY_EN)
//   o_outbox_wr/_data   OUTBOX push strobe and byte (mirror of o_tx_data)
//   o_busy              high outside IDLE
//   o_sent_cnt          bytes handed to TX (wraps)
//   o_underflow         sticky: a step request found INBOX empty
module inbox_tx_sequencer
    import inbox_tx_sequencer_pkg::*;
#(
    parameter int DW         = BOX_DW,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    input  logic             i_run,
    input  logic             i_inbox_empty_n,
    input  logic [DW-1:0]    i_inbox_data,
    output logic             o_inbox_rd,
    input  logic             i_tx_busy,
    output logic             o_tx_wr,
    output logic [DW-1:0]    o_tx_data,
    input  logic             i_outbox_full,
    output logic             o_outbox_wr,
    output logic [DW-1:0]    o_outbox_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_sent_cnt,
    output logic             o_underflow
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    seq_state_t    state;
    logic          pend_step;
    logic [GW-1:0] gap_cnt;
    logic          step_req;
    logic          room;
    logic          copy_en;

    // A step arriving while IDLE is served directly so the pop
    // lands on the very next cycle; pend_step covers busy periods.
    assign step_req = pend_step | i_step;

`ifdef OUTBOX_COPY_EN
    assign room    = ~i_outbox_full;
    assign copy_en = 1'b1;
`else
    logic unused_outbox_full;
    assign unused_outbox_full = i_outbox_full;
    assign room    = 1'b1;
    assign copy_en = 1'b0;
`endif

    assign o_outbox_data = o_tx_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= SEQ_IDLE;
            pend_step   <= 1'b0;
            gap_cnt     <= '0;
            o_inbox_rd  <= 1'b0;
            o_tx_wr     <= 1'b0;
            o_outbox_wr <= 1'b0;
            o_tx_data   <= '0;
            o_busy      <= 1'b0;
            o_sent_cnt  <= '0;
            o_underflow <= 1'b0;
        end else begin
            o_inbox_rd  <= 1'b0;
            o_tx_wr     <= 1'b0;
            o_outbox_wr <= 1'b0;
            if (i_step)
                pend_step <= 1'b1;

            case (state)
                SEQ_IDLE: begin
                    if ((step_req | i_run) && i_inbox_empty_n &&
                        !i_tx_busy && room) begin
                        state      <= SEQ_POP;
                        o_inbox_rd <= 1'b1;
                        o_tx_data  <= i_inbox_data;
                        o_busy     <= 1'b1;
                        pend_step  <= 1'b0;
                    end else if (step_req && !i_inbox_empty_n) begin
                        // Drain mode waits quietly; explicit steps flag it.
                        o_underflow <= 1'b1;
                        pend_step   <= 1'b0;
                    end
                end
                SEQ_POP: begin
                    state       <= SEQ_SEND;
                    o_tx_wr     <= 1'b1;
                    o_outbox_wr <= copy_en;
                    o_sent_cnt  <= o_sent_cnt + 1'b1;
                end
                SEQ_SEND: begin
                    // Give txuartlite a cycle to raise busy.
                    state <= SEQ_ACK;
                end
                SEQ_ACK: begin
                    state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (!i_tx_busy) begin
                        if (i_run && (GAP_CYCLES > 0)) begin
                            state   <= SEQ_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state  <= SEQ_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                SEQ_GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= SEQ_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= SEQ_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
